// File: rtl/ctrl_pipe_pkg.sv
// Shared constants and stage-entry type for the control pipeline chain.
// Optional stall statistics are enabled with CTRL_PIPE_STATS_EN.
package ctrl_pipe_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 3;
    localparam int STAT_W    = 32;

    typedef struct packed {
        logic                 valid;
        logic [DEF_WIDTH-1:0] data;
    } stage_entry_t;

endpackage

// File: rtl/ctrl_pipe_stage.sv
// One register stage of the control chain: a valid bit, a payload,
// and the accept condition toward its upstream neighbour.
module ctrl_pipe_stage
    import ctrl_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             down_accept,
    output logic             accept,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // An empty slot always takes the upstream entry, even a bubble.
    assign accept = !valid || down_accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (en && accept) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/ctrl_pipe_chain.sv
// Stallable, flushable valid/ready register chain for control bundles.
// Define CTRL_PIPE_STATS_EN to add the saturating stall_cycles counter.
module ctrl_pipe_chain
    import ctrl_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       stall,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef CTRL_PIPE_STATS_EN
    ,
    output logic [STAT_W-1:0]          stall_cycles
`endif
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic             move;
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] acc;
    logic [WIDTH-1:0] dat [DEPTH];

    assign move = !stall && !flush;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_v;
        logic [WIDTH-1:0] up_d;
        logic             dn_acc;

        if (i == 0) begin : g_head
            assign up_v = in_valid;
            assign up_d = in_data;
        end else begin : g_body
            assign up_v = vld[i-1];
            assign up_d = dat[i-1];
        end

        // Downstream frees a slot if any later stage is empty or the sink drains.
        if (i == DEPTH-1) begin : g_tail
            assign dn_acc = out_ready;
        end else begin : g_mid
            assign dn_acc = out_ready || !(&vld[DEPTH-1:i+1]);
        end

        ctrl_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk         (clk),
            .reset       (reset),
            .en          (!stall),
            .flush       (flush),
            .up_valid    (up_v),
            .up_data     (up_d),
            .down_accept (dn_acc),
            .accept      (acc[i]),
            .valid       (vld[i]),
            .data        (dat[i])
        );
    end

    assign in_ready  = acc[0] && move;
    assign out_valid = vld[DEPTH-1] && move;
    assign out_data  = out_valid ? dat[DEPTH-1] : '0;

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(vld[i]);
        end
    end

`ifdef CTRL_PIPE_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall && !flush && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + STAT_W'(1);
        end
    end
`else
    // Default build carries no statistics state.
`endif

endmodule
